// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the LC-3 load/store engine.
//  - op_e    : operation encodings presented on the command side
//  - state_e : engine state encodings (also exposed on the debug port)
//  - TMO_W   : width of the per-access wait counter
//  - helpers : decode of the indirect / store bits of an op
package mem_access_unit_pkg;

  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_LDI = 2'b01,
    OP_ST  = 2'b10,
    OP_STI = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR  = 3'd1,
    S_GAP  = 3'd2,
    S_ACC  = 3'd3,
    S_WB   = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  // Bit 0 selects the two-access (pointer fetch first) form.
  function automatic logic op_is_indirect(op_e op);
    return op[0];
  endfunction

  // Bit 1 selects a write for the data access.
  function automatic logic op_is_store(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the command-side and memory-side signals of mem_access_unit.
//  Command side : start, op, addr, st_data in; busy, done, err, load_data, rd_le out
//  Memory side  : mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ack in
//  slave modport  : the engine's view
//  master modport : the environment's view (command source + memory)
//
// Memory handshake: mem_req acts as valid and mem_ack as ready. An access
// completes on the rising edge where mem_req and mem_ack are both high;
// mem_we/mem_addr/mem_wdata are held unchanged from the rise of mem_req up to
// that edge, mem_rdata is only meaningful in the ack cycle, mem_req is low in
// the cycle after the completing edge, and mem_ack with mem_req low is ignored.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 16
) ();

  logic              start;
  op_e               op;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] st_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] load_data;
  logic              rd_le;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  start, op, addr, st_data, mem_rdata, mem_ack,
    output busy, done, err, load_data, rd_le,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output start, op, addr, st_data, mem_rdata, mem_ack,
    input  busy, done, err, load_data, rd_le,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Per-access wait counter for the memory handshake.
//  clk_i, rst_i : clock, synchronous active-high reset
//  clr_i        : zero the count (has priority over en_i)
//  en_i         : count one request cycle
//  expired_o    : high in the TIMEOUT-th consecutive counted cycle
// TIMEOUT = 0 disables expiry entirely.
module mem_timeout_ctr
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // The count equals the number of already-finished request cycles, so
  // matching TIMEOUT-1 means the current cycle is the last one allowed.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// LC-3 load/store engine: runs LD/LDR, LDI, ST/STR and STI over a req/ack
// memory handshake; indirect forms first fetch a pointer, then access it.
//  clk_i, rst_i : clock, synchronous active-high reset
//  bus          : command + memory signals (slave view, see interface)
//  dbg_state_o  : current engine state (state_e encoding)
// All bus outputs come straight from flops.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_access_unit_if.slave   bus,
  output logic [2:0]         dbg_state_o
);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rd_le_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              store_q;
  logic [DATA_W-1:0] load_data_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic tmo_clr;
  logic tmo_expired;

  // Holding the counter clear whenever REQ is low (or the access completes)
  // guarantees it starts from zero at every REQ rise.
  assign tmo_clr = !mem_req_q || bus.mem_ack;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (mem_req_q),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_le_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      store_q     <= 1'b0;
      load_data_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_le_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            store_q     <= op_is_store(bus.op);
            mem_addr_q  <= bus.addr;
            mem_wdata_q <= bus.st_data;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            if (op_is_indirect(bus.op)) begin
              mem_we_q <= 1'b0;
              state_q  <= S_PTR;
            end else begin
              mem_we_q <= op_is_store(bus.op);
              state_q  <= S_ACC;
            end
          end
        end
        S_PTR: begin
          if (bus.mem_ack) begin
            // The fetched pointer becomes the data address, used verbatim.
            mem_addr_q <= bus.mem_rdata;
            mem_req_q  <= 1'b0;
            state_q    <= S_GAP;
          end else if (tmo_expired) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_FIN;
          end
        end
        S_GAP: begin
          mem_req_q <= 1'b1;
          mem_we_q  <= store_q;
          state_q   <= S_ACC;
        end
        S_ACC: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (store_q) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              load_data_q <= bus.mem_rdata;
              rd_le_q     <= 1'b1;
              state_q     <= S_WB;
            end
          end else if (tmo_expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_FIN;
          end
        end
        S_WB: begin
          done_q  <= 1'b1;
          state_q <= S_FIN;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_le     = rd_le_q;
  assign bus.load_data = load_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed LC-3 load/store scenarios followed by
// random operations, each compared against a word-level reference model
// (expected memory image, expected access list, expected timing).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int W   = 16;
  localparam int TMO = 4;
  localparam logic [W-1:0] RESTART_ADDR = 16'h7777;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  mem_access_unit_if #(.DATA_W(W)) bus ();

  mem_access_unit #(
    .DATA_W  (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [W-1:0] mem     [0:65535];
  logic [W-1:0] exp_mem [0:65535];
  bit ack_en        = 1'b1;
  bit ack_when_idle = 1'b0;
  int ack_delay     = 0;
  int wait_cnt      = 0;

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    #1;
    if (bus.mem_req) begin
      if (ack_en && wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = ack_when_idle;
      bus.mem_rdata = 16'($urandom);
      wait_cnt      = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];     // expected access addresses, in order
  logic         exp_we_q[$];  // expected write flag per access
  int           exp_done, exp_req_cycles, exp_rdle;
  logic         exp_err;
  logic [W-1:0] exp_word, exp_load, exp_target;

  logic [W-1:0] obs_addr_q[$];
  logic         obs_we_q[$];
  logic [W-1:0] obs_wdata_q[$];
  int           obs_gap_q[$];
  int  obs_done_cyc, obs_first_req, obs_req_cycles, obs_stab, obs_ackv;
  int  obs_rdle_cnt, obs_rdle_cyc, obs_busy_low, obs_err_stray, obs_post_viol;
  logic         obs_done_err;
  logic [W-1:0] obs_rdle_data, obs_final_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_err"},   32'(bus.err), 0);
    check({tag, "_rdle"},  32'(bus.rd_le), 0);
    check({tag, "_req"},   32'(bus.mem_req), 0);
    check({tag, "_we"},    32'(bus.mem_we), 0);
    check({tag, "_load"},  32'(bus.load_data), 0);
    check({tag, "_addr"},  32'(bus.mem_addr), 0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Reference model: what a whole operation should look like at word level.
  task automatic model_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] d,
                          input int delay, input bit tmo);
    bit ind   = (op == OP_LDI) || (op == OP_STI);
    bit store = (op == OP_ST)  || (op == OP_STI);
    exp_q.delete();
    exp_we_q.delete();
    if (ind) begin
      exp_q.push_back(a);
      exp_we_q.push_back(1'b0);
    end
    if (tmo) begin
      if (!ind) begin
        exp_q.push_back(a);
        exp_we_q.push_back(store);
      end
      exp_req_cycles = TMO;
      exp_done       = TMO + 1;
      exp_err        = 1'b1;
      exp_rdle       = 0;
      exp_target     = a;
    end else begin
      exp_target = ind ? exp_mem[a] : a;
      exp_q.push_back(exp_target);
      exp_we_q.push_back(store);
      exp_req_cycles = exp_q.size() * (delay + 1);
      exp_done       = exp_req_cycles + (ind ? 1 : 0) + (store ? 0 : 1) + 1;
      exp_err        = 1'b0;
      if (store) begin
        exp_mem[exp_target] = d;
        exp_rdle = 0;
      end else begin
        exp_word = exp_mem[exp_target];
        exp_load = exp_word;
        exp_rdle = 1;
      end
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] d,
                        input int restart);
    logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [W-1:0] p_addr = '0, p_wdata = '0;
    int low_run = 0;
    obs_addr_q.delete(); obs_we_q.delete(); obs_wdata_q.delete(); obs_gap_q.delete();
    obs_done_cyc = -1; obs_first_req = -1; obs_req_cycles = 0; obs_stab = 0; obs_ackv = 0;
    obs_rdle_cnt = 0; obs_rdle_cyc = -1; obs_busy_low = 0; obs_err_stray = 0;
    obs_post_viol = 0; obs_done_err = 1'b0; obs_rdle_data = '0;
    @(negedge clk);
    bus.op = op; bus.addr = a; bus.st_data = d; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        obs_req_cycles++;
        if (obs_first_req < 0) obs_first_req = c;
        if (!p_req) begin
          obs_addr_q.push_back(bus.mem_addr);
          obs_we_q.push_back(bus.mem_we);
          obs_wdata_q.push_back(bus.mem_wdata);
          if (obs_addr_q.size() > 1) obs_gap_q.push_back(low_run);
          low_run = 0;
        end else if (p_ack) begin
          obs_ackv++;
        end else if (bus.mem_addr !== p_addr || bus.mem_we !== p_we || bus.mem_wdata !== p_wdata) begin
          obs_stab++;
        end
      end else if (obs_addr_q.size() > 0) begin
        low_run++;
      end
      if (bus.rd_le) begin
        obs_rdle_cnt++;
        obs_rdle_cyc  = c;
        obs_rdle_data = bus.load_data;
      end
      if (!bus.busy) obs_busy_low++;
      if (bus.err && !bus.done) obs_err_stray++;
      p_req = bus.mem_req; p_ack = bus.mem_ack && bus.mem_req; p_we = bus.mem_we;
      p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
      if (bus.done) begin
        obs_done_cyc = c;
        obs_done_err = bus.err;
        break;
      end
      bus.start = (c == restart);
      if (c == restart) begin
        bus.op = OP_ST; bus.addr = RESTART_ADDR; bus.st_data = 16'hDEAD;
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.busy || bus.mem_req || bus.done || bus.rd_le) obs_post_viol++;
    end
    obs_final_load = bus.load_data;
  endtask

  task automatic run_and_check(input string tag, input op_e op, input logic [W-1:0] a,
                               input logic [W-1:0] d, input int delay, input bit tmo,
                               input int restart);
    ack_delay = delay;
    ack_en    = !tmo;
    model_op(op, a, d, delay, tmo);
    run_op(op, a, d, restart);
    ack_en = 1'b1;
    check({tag, "_done_cyc"},   32'(obs_done_cyc), 32'(exp_done));
    check({tag, "_err"},        32'(obs_done_err), 32'(exp_err));
    check({tag, "_first_req"},  32'(obs_first_req), 1);
    check({tag, "_req_cycles"}, 32'(obs_req_cycles), 32'(exp_req_cycles));
    check({tag, "_n_access"},   32'(obs_addr_q.size()), 32'(exp_q.size()));
    if (obs_addr_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        check($sformatf("%s_acc%0d_addr", tag, i), 32'(obs_addr_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_acc%0d_we", tag, i),   32'(obs_we_q[i]), 32'(exp_we_q[i]));
        if (exp_we_q[i]) check($sformatf("%s_acc%0d_wdata", tag, i), 32'(obs_wdata_q[i]), 32'(d));
      end
    end
    if (exp_q.size() == 2) begin
      check({tag, "_gap"}, (obs_gap_q.size() == 1) ? 32'(obs_gap_q[0]) : 32'hFFFF_FFFF, 1);
    end
    check({tag, "_stable"},    32'(obs_stab), 0);
    check({tag, "_req_after_ack"}, 32'(obs_ackv), 0);
    check({tag, "_rdle_cnt"},  32'(obs_rdle_cnt), 32'(exp_rdle));
    if (exp_rdle == 1) begin
      check({tag, "_rdle_cyc"},  32'(obs_rdle_cyc), 32'(exp_done - 1));
      check({tag, "_rdle_data"}, 32'(obs_rdle_data), 32'(exp_word));
    end
    check({tag, "_load_hold"}, 32'(obs_final_load), 32'(exp_load));
    check({tag, "_busy"},      32'(obs_busy_low), 0);
    check({tag, "_err_stray"}, 32'(obs_err_stray), 0);
    check({tag, "_post_idle"}, 32'(obs_post_viol), 0);
    check({tag, "_mem"},       32'(mem[exp_target]), 32'(exp_mem[exp_target]));
  endtask

  task automatic set_mem(input logic [W-1:0] a, input logic [W-1:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int diffs;
    bus.start = 1'b0; bus.op = OP_LD; bus.addr = '0; bus.st_data = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    exp_load = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      exp_mem[i] = mem[i];
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // LD, ack in first REQ cycle
    set_mem(16'h3000, 16'hABCD);
    run_and_check("ld", OP_LD, 16'h3000, 16'h0000, 0, 1'b0, -1);

    // Reset in the pointer fetch of an LDI
    ack_en = 1'b0;
    @(negedge clk);
    bus.op = OP_LDI; bus.addr = 16'h3000; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("rst_mid_req", 32'(bus.mem_req), 1);
    check("rst_mid_addr", 32'(bus.mem_addr), 32'h3000);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    exp_load = '0;
    begin
      int stray = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.done || bus.rd_le || bus.mem_req || bus.busy) stray++;
      end
      check("rst_mid_quiet", 32'(stray), 0);
    end
    ack_en = 1'b1;

    // ST with ACK in the 4th REQ cycle (last one before timeout)
    run_and_check("st", OP_ST, 16'h4000, 16'h1234, 3, 1'b0, -1);

    // LDI and STI
    set_mem(16'h3000, 16'h5000);
    set_mem(16'h5000, 16'hBEEF);
    run_and_check("ldi", OP_LDI, 16'h3000, 16'h0000, 0, 1'b0, -1);
    set_mem(16'h3002, 16'h6000);
    run_and_check("sti", OP_STI, 16'h3002, 16'h00FF, 0, 1'b0, -1);

    // START again while busy is ignored
    run_and_check("restart", OP_LDI, 16'h3000, 16'h0000, 2, 1'b0, 2);
    check("restart_mem", 32'(mem[RESTART_ADDR]), 32'(exp_mem[RESTART_ADDR]));

    // Timeouts: direct access and pointer fetch
    run_and_check("tmo_ld", OP_LD, 16'h1234, 16'h0000, 0, 1'b1, -1);
    run_and_check("tmo_sti", OP_STI, 16'h2222, 16'h5555, 0, 1'b1, -1);

    // ACK while idle is ignored
    ack_when_idle = 1'b1;
    begin
      int stray = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.busy || bus.done || bus.rd_le || bus.mem_req) stray++;
      end
      check("idle_ack", 32'(stray), 0);
    end
    ack_when_idle = 1'b0;

    // Random operations
    for (int n = 0; n < 30; n++) begin
      op_e op = op_e'($urandom_range(0, 3));
      ack_when_idle = 1'($urandom_range(0, 1));
      run_and_check($sformatf("rnd%0d", n), op, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 3), 1'b0, ($urandom_range(0, 3) == 0) ? 1 : -1);
    end
    ack_when_idle = 1'b0;

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
